sig_ctrl: RTL and testbench
===========================

SIG_CTRL -- requirements
Module: sig_ctrl

Interface
REQ-001 Parameter DEB_CYCLES, default 1000000: consecutive stable cycles for a key to be accepted (20 ms at 50 MHz); legal range 2..2^24-1.
REQ-002 Parameter REPEAT_DLY, default 25000000: held cycles before the first auto-repeat on key_inc; used only under KEY_REPEAT_EN.
REQ-003 Parameter REPEAT_PER, default 5000000: cycles between subsequent auto-repeats; used only under KEY_REPEAT_EN.
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 key_sel  input  1  raw active-low push button that advances the edit-field pointer.
REQ-007 key_inc  input  1  raw active-low push button that increments the selected field.
REQ-008 key_ok  input  1  raw active-low push button that toggles between edit and run.
REQ-009 cnt_sig  output  2  waveform select: 0 sine, 1 square, 2 triangle, 3 sawtooth.
REQ-010 cnt_amp  output  2  amplitude shift code for the downstream generator.
REQ-011 cnt_fre  output  2  frequency code for the downstream generator.
REQ-012 cnt_phase  output  2  phase/duty code for the downstream generator.
REQ-013 confirm  output  1  high while in RUN; enables the downstream generator.
REQ-014 field_sel  output  2  field currently being edited (0 sig, 1 amp, 2 fre, 3 phase), for LED display.

Function
REQ-015 Each key input shall pass through a 2-flop synchronizer before any other use.
REQ-016 Each key shall have its own debouncer: a counter that resets whenever the synchronized level equals the debounced level; the debounced level takes the synchronized level when the counter reaches DEB_CYCLES-1.
REQ-017 A press event shall be a one-cycle pulse, registered one cycle after the debounced level goes from 1 to 0; releases generate no event.
REQ-018 Glitches shorter than DEB_CYCLES cycles shall generate no event.
REQ-019 The FSM shall have two states: EDIT (confirm=0) and RUN (confirm=1).
REQ-020 In EDIT, a sel event shall advance field_sel by 1 modulo 4 (3 wraps to 0).
REQ-021 In EDIT, an inc event shall increment the field addressed by field_sel by 1 modulo 4 (3 wraps to 0), leaving the other fields unchanged.
REQ-022 An ok event shall move EDIT to RUN and RUN to EDIT; field_sel and all cnt_* registers shall keep their values across the transition.
REQ-023 In RUN, sel and inc events shall be ignored.
REQ-024 If events coincide in one cycle, only the highest-priority event shall act: ok over sel over inc.
REQ-025 All outputs shall be registered and shall update on the clock edge that follows the event pulse (event pulse to output: 1 cycle).
REQ-026 The cnt_* outputs shall be stable for the whole time confirm is high.

Reset
REQ-027 While rst is high: cnt_sig=0, cnt_amp=1, cnt_fre=0, cnt_phase=0, confirm=0, field_sel=0, state EDIT, debounced levels=1 (released), counters=0, synchronizer flops=1.
REQ-028 Asserting rst in the middle of a press or in RUN shall force the reset values immediately; a key still held when rst is released shall generate an event only after it has been released and pressed again.

Configuration
REQ-029 With macro SIG_CTRL_KEY_REPEAT_EN defined: in EDIT, holding key_inc debounced-low shall produce an extra inc event after REPEAT_DLY cycles and then one every REPEAT_PER cycles until release; the repeat counter shall clear on release, on an ok event and on reset.
REQ-030 Without SIG_CTRL_KEY_REPEAT_EN: no repeat logic shall be built, and each press shall produce exactly one inc event however long it is held.

Verification (DEB_CYCLES=4, REPEAT_DLY=20, REPEAT_PER=8)
REQ-031 Reset release -> cnt_sig=0, cnt_amp=1, cnt_fre=0, cnt_phase=0, confirm=0, field_sel=0.
REQ-032 key_inc low for 3 cycles, then high -> no change; key_inc low for 10 cycles -> cnt_sig=1, with the output changing at the fixed latency set by REQ-015 to REQ-025.
REQ-033 Four sel presses -> field_sel runs 1,2,3,0; with field_sel=1, five inc presses -> cnt_amp=2 (1+5 mod 4).
REQ-034 ok press -> confirm=1; then sel and inc presses -> all outputs unchanged; second ok press -> confirm=0 with the values retained.
REQ-035 Debounced sel and ok events in the same cycle -> confirm toggles and field_sel is unchanged; rst pulse while in RUN -> reset values immediately.
REQ-036 With SIG_CTRL_KEY_REPEAT_EN, key_inc held for 40 cycles past debounce -> 1+1+2 = 4 increments; without the macro -> 1 increment.

Source files
------------

// File: rtl/sig_ctrl_if.sv
// Push-button panel to signal-generator control bus.
// The master side drives the raw keys; the slave side (sig_ctrl) drives the settings.
interface sig_ctrl_if;
  logic       key_sel;
  logic       key_inc;
  logic       key_ok;
  logic [1:0] cnt_sig;
  logic [1:0] cnt_amp;
  logic [1:0] cnt_fre;
  logic [1:0] cnt_phase;
  logic       confirm;
  logic [1:0] field_sel;

  modport master (
    output key_sel, key_inc, key_ok,
    input  cnt_sig, cnt_amp, cnt_fre, cnt_phase, confirm, field_sel
  );

  modport slave (
    input  key_sel, key_inc, key_ok,
    output cnt_sig, cnt_amp, cnt_fre, cnt_phase, confirm, field_sel
  );
endinterface

// File: rtl/sig_ctrl.sv
// Three-key edit/run controller for a signal generator: synchronise, debounce, edit fields.
// Optional auto-repeat on key_inc is built only when SIG_CTRL_KEY_REPEAT_EN is defined.
module sig_ctrl #(
  parameter int unsigned DEB_CYCLES = 1000000,
  parameter int unsigned REPEAT_DLY = 25000000,
  parameter int unsigned REPEAT_PER = 5000000
) (
  input  logic     clk,
  input  logic     rst,
  sig_ctrl_if.slave bus
);

  localparam int unsigned NK    = 3;
  localparam int unsigned K_SEL = 0;
  localparam int unsigned K_INC = 1;
  localparam int unsigned K_OK  = 2;

  localparam logic [23:0] DEB_LAST = 24'(DEB_CYCLES - 1);

  if (DEB_CYCLES < 2 || DEB_CYCLES > 32'h00FF_FFFF || REPEAT_DLY < 1 || REPEAT_PER < 1)
  begin : g_bad_param
    $error("sig_ctrl: parameter out of legal range");
  end

  typedef enum logic {
    EDIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  logic [NK-1:0] key_raw;
  logic [NK-1:0] sync1;
  logic [NK-1:0] sync2;
  logic [NK-1:0] deb;
  logic [NK-1:0] deb_d;
  logic [NK-1:0] armed;
  logic [NK-1:0] press;
  logic [23:0]   deb_cnt [NK];
  logic [1:0]    vld;

  logic ev_ok;
  logic ev_sel;
  logic ev_inc;

  state_t         state;
  state_t         state_nxt;
  logic [1:0]     field_q;
  logic [1:0]     field_nxt;
  logic [3:0][1:0] cnt_q;
  logic [3:0][1:0] cnt_nxt;
  logic           confirm_q;

  assign key_raw = {bus.key_ok, bus.key_inc, bus.key_sel};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '1;
      sync2 <= '1;
      vld   <= '0;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
      vld   <= {vld[0], 1'b1};
    end
  end

  // A key is armed only once a genuine released sample has reached sync2 after
  // reset, so a button held across reset cannot fire until pressed again.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb   <= '1;
      deb_d <= '1;
      armed <= '0;
      press <= '0;
      for (int unsigned k = 0; k < NK; k++) begin
        deb_cnt[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < NK; k++) begin
        deb_d[k] <= deb[k];
        press[k] <= armed[k] & deb_d[k] & ~deb[k];
        if (vld[1] && sync2[k]) begin
          armed[k] <= 1'b1;
        end
        if (sync2[k] == deb[k]) begin
          deb_cnt[k] <= '0;
        end else if (deb_cnt[k] == DEB_LAST) begin
          deb[k]     <= sync2[k];
          deb_cnt[k] <= '0;
        end else begin
          deb_cnt[k] <= deb_cnt[k] + 24'd1;
        end
      end
    end
  end

  assign ev_ok  = press[K_OK];
  assign ev_sel = press[K_SEL];

`ifdef SIG_CTRL_KEY_REPEAT_EN
  localparam int unsigned RMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int unsigned RW   = (RMAX < 2) ? 1 : $clog2(RMAX);
  localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DLY - 1);
  localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PER - 1);

  logic [RW-1:0] rep_cnt;
  logic          rep_first;
  logic          rep_pulse;

  // First repeat after REPEAT_DLY held cycles, then one every REPEAT_PER.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_cnt   <= '0;
      rep_first <= 1'b0;
      rep_pulse <= 1'b0;
    end else if (ev_ok || deb[K_INC] || !armed[K_INC] || state != EDIT) begin
      rep_cnt   <= '0;
      rep_first <= 1'b0;
      rep_pulse <= 1'b0;
    end else begin
      rep_pulse <= 1'b0;
      if (!rep_first && rep_cnt == DLY_LAST) begin
        rep_pulse <= 1'b1;
        rep_first <= 1'b1;
        rep_cnt   <= '0;
      end else if (rep_first && rep_cnt == PER_LAST) begin
        rep_pulse <= 1'b1;
        rep_cnt   <= '0;
      end else begin
        rep_cnt <= rep_cnt + 1'b1;
      end
    end
  end

  assign ev_inc = press[K_INC] | rep_pulse;
`else
  assign ev_inc = press[K_INC];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EDIT;
      field_q   <= '0;
      cnt_q     <= {2'd0, 2'd0, 2'd1, 2'd0};
      confirm_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      field_q   <= field_nxt;
      cnt_q     <= cnt_nxt;
      confirm_q <= (state_nxt == RUN);
    end
  end

  // Priority ok > sel > inc; in RUN only ok acts.
  always_comb begin
    state_nxt = state;
    field_nxt = field_q;
    cnt_nxt   = cnt_q;
    case (state)
      EDIT: begin
        if (ev_ok) begin
          state_nxt = RUN;
        end else if (ev_sel) begin
          field_nxt = field_q + 2'd1;
        end else if (ev_inc) begin
          cnt_nxt[field_q] = cnt_q[field_q] + 2'd1;
        end
      end
      RUN: begin
        if (ev_ok) begin
          state_nxt = EDIT;
        end
      end
      default: state_nxt = EDIT;
    endcase
  end

  assign bus.cnt_sig   = cnt_q[0];
  assign bus.cnt_amp   = cnt_q[1];
  assign bus.cnt_fre   = cnt_q[2];
  assign bus.cnt_phase = cnt_q[3];
  assign bus.confirm   = confirm_q;
  assign bus.field_sel = field_q;

endmodule

// File: tb/tb_sig_ctrl.sv
// Self-checking bench for sig_ctrl: vector table of key presses plus hand sequences
// for latency, reset in RUN, key held across reset and (optional) auto-repeat.
module tb_sig_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    sig_ctrl_if bus ();

    sig_ctrl #(
        .DEB_CYCLES(4),
        .REPEAT_DLY(20),
        .REPEAT_PER(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // mask bits: [0] sel, [1] inc, [2] ok
    typedef struct {
        logic [2:0]  keys;
        int unsigned low;
        logic [1:0]  sig;
        logic [1:0]  amp;
        logic [1:0]  fre;
        logic [1:0]  ph;
        logic        conf;
        logic [1:0]  fs;
        string       name;
    } vec_t;

    vec_t vecs [$];

    function automatic logic [10:0] outs();
        return {bus.cnt_sig, bus.cnt_amp, bus.cnt_fre, bus.cnt_phase, bus.confirm, bus.field_sel};
    endfunction

    function automatic logic [10:0] pack(logic [1:0] s, logic [1:0] a, logic [1:0] f,
                                         logic [1:0] p, logic c, logic [1:0] fs);
        return {s, a, f, p, c, fs};
    endfunction

    task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got sig/amp/fre/ph/conf/fs=%b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] mask);
        bus.key_sel = ~mask[0];
        bus.key_inc = ~mask[1];
        bus.key_ok  = ~mask[2];
    endtask

    task automatic cycles(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [2:0] mask, input int unsigned low);
        if (mask != 3'b000) begin
            drive(mask);
            cycles(low);
            drive(3'b000);
        end
        cycles(16);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   changes;
        int   exp_changes;
        logic [1:0] prev;

        //              keys    low sig   amp   fre   ph    conf  fs
        vecs.push_back('{3'b000, 0, 2'd0, 2'd1, 2'd0, 2'd0, 1'b0, 2'd0, "reset"});
        vecs.push_back('{3'b010, 3, 2'd0, 2'd1, 2'd0, 2'd0, 1'b0, 2'd0, "inc_glitch3"});
        vecs.push_back('{3'b010, 10, 2'd1, 2'd1, 2'd0, 2'd0, 1'b0, 2'd0, "inc_sig"});
        vecs.push_back('{3'b001, 10, 2'd1, 2'd1, 2'd0, 2'd0, 1'b0, 2'd1, "sel1"});
        vecs.push_back('{3'b001, 10, 2'd1, 2'd1, 2'd0, 2'd0, 1'b0, 2'd2, "sel2"});
        vecs.push_back('{3'b001, 10, 2'd1, 2'd1, 2'd0, 2'd0, 1'b0, 2'd3, "sel3"});
        vecs.push_back('{3'b001, 10, 2'd1, 2'd1, 2'd0, 2'd0, 1'b0, 2'd0, "sel_wrap"});
        vecs.push_back('{3'b001, 10, 2'd1, 2'd1, 2'd0, 2'd0, 1'b0, 2'd1, "sel_amp"});
        vecs.push_back('{3'b010, 10, 2'd1, 2'd2, 2'd0, 2'd0, 1'b0, 2'd1, "amp_inc1"});
        vecs.push_back('{3'b010, 10, 2'd1, 2'd3, 2'd0, 2'd0, 1'b0, 2'd1, "amp_inc2"});
        vecs.push_back('{3'b010, 10, 2'd1, 2'd0, 2'd0, 2'd0, 1'b0, 2'd1, "amp_inc3_wrap"});
        vecs.push_back('{3'b010, 10, 2'd1, 2'd1, 2'd0, 2'd0, 1'b0, 2'd1, "amp_inc4"});
        vecs.push_back('{3'b010, 10, 2'd1, 2'd2, 2'd0, 2'd0, 1'b0, 2'd1, "amp_inc5"});
        vecs.push_back('{3'b100, 10, 2'd1, 2'd2, 2'd0, 2'd0, 1'b1, 2'd1, "ok_run"});
        vecs.push_back('{3'b001, 10, 2'd1, 2'd2, 2'd0, 2'd0, 1'b1, 2'd1, "run_sel_ignored"});
        vecs.push_back('{3'b010, 10, 2'd1, 2'd2, 2'd0, 2'd0, 1'b1, 2'd1, "run_inc_ignored"});
        vecs.push_back('{3'b100, 10, 2'd1, 2'd2, 2'd0, 2'd0, 1'b0, 2'd1, "ok_edit"});
        vecs.push_back('{3'b101, 10, 2'd1, 2'd2, 2'd0, 2'd0, 1'b1, 2'd1, "sel_ok_same"});
        vecs.push_back('{3'b100, 10, 2'd1, 2'd2, 2'd0, 2'd0, 1'b0, 2'd1, "ok_back"});

        drive(3'b000);
        cycles(3);
        rst = 1'b0;
        cycles(4);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            press(v.keys, v.low);
            check(v.name, outs(), pack(v.sig, v.amp, v.fre, v.ph, v.conf, v.fs));
        end

        // Latency: key low driven just after edge 0, output moves on edge 8.
        drive(3'b010);
        cycles(7);
        check("lat_before", outs(), pack(2'd1, 2'd2, 2'd0, 2'd0, 1'b0, 2'd1));
        cycles(1);
        check("lat_after", outs(), pack(2'd1, 2'd3, 2'd0, 2'd0, 1'b0, 2'd1));
        cycles(2);
        drive(3'b000);
        cycles(16);

        // Reset asserted asynchronously while in RUN.
        press(3'b100, 10);
        check("run_before_rst", outs(), pack(2'd1, 2'd3, 2'd0, 2'd0, 1'b1, 2'd1));
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_in_run", outs(), pack(2'd0, 2'd1, 2'd0, 2'd0, 1'b0, 2'd0));

        // Key held across reset release must not fire until re-pressed.
        drive(3'b010);
        cycles(3);
        rst = 1'b0;
        cycles(20);
        check("held_thru_rst", outs(), pack(2'd0, 2'd1, 2'd0, 2'd0, 1'b0, 2'd0));
        drive(3'b000);
        cycles(16);
        check("held_release", outs(), pack(2'd0, 2'd1, 2'd0, 2'd0, 1'b0, 2'd0));
        press(3'b010, 10);
        check("repress_after_rst", outs(), pack(2'd1, 2'd1, 2'd0, 2'd0, 1'b0, 2'd0));

        // Long hold: debounce falls at edge 6, release drives deb high at edge 46.
`ifdef SIG_CTRL_KEY_REPEAT_EN
        exp_changes = 4;
`else
        exp_changes = 1;
`endif
        changes = 0;
        prev = bus.cnt_sig;
        drive(3'b010);
        for (int k = 1; k <= 70; k++) begin
            cycles(1);
            if (k == 40) drive(3'b000);
            if (bus.cnt_sig != prev) changes++;
            prev = bus.cnt_sig;
        end
        check_int("hold_inc_count", changes, exp_changes);
        check("hold_final", outs(),
              pack(2'((1 + exp_changes) % 4), 2'd1, 2'd0, 2'd0, 1'b0, 2'd0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
